// File: rtl/cache_fill_ctrl.sv
// Cache-miss block fill controller: pipelined reads of one block, in sequential
// or critical-word-first order, with early forwarding of the missed word.
module cache_fill_ctrl #(
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 16,
   parameter int WORDS_PER_BLOCK = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CWF             = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               miss_detected,
   input  logic [ADDR_W-1:0]                  miss_address,
   output logic                               mem_req,
   input  logic                               mem_ready,
   output logic [ADDR_W-1:0]                  mem_addr,
   input  logic [DATA_W-1:0]                  mem_rdata,
   input  logic                               mem_rvalid,
   output logic                               fsm_busy,
   output logic                               write_data_array,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_idx,
   output logic [DATA_W-1:0]                  write_data,
   output logic                               write_tag_array,
   output logic [ADDR_W-1:0]                  fill_addr,
   output logic [DATA_W-1:0]                  req_data,
   output logic                               req_data_valid
);

   localparam int BYTE_W = $clog2(DATA_W / 8);
   localparam int IDX_W  = $clog2(WORDS_PER_BLOCK);
   localparam int OFF_W  = IDX_W + BYTE_W;
   localparam int CNT_W  = IDX_W + 1;

   localparam logic [CNT_W-1:0]  BLOCK_CNT = CNT_W'(WORDS_PER_BLOCK);
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
   localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << OFF_W) - 1);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t            state, state_next;
   logic [IDX_W-1:0]  crit;
   logic [CNT_W-1:0]  issued, returned, outstanding;
   logic [IDX_W-1:0]  req_idx, ret_idx;
   logic              issue_fire, ret_fire;

   // Word order: plain ascending, or rotated so the missed word comes first.
   assign req_idx = (CWF != 0) ? crit + issued[IDX_W-1:0]   : issued[IDX_W-1:0];
   assign ret_idx = (CWF != 0) ? crit + returned[IDX_W-1:0] : returned[IDX_W-1:0];

   assign ret_fire   = (state == FILL) && mem_rvalid && (outstanding != '0);
   assign issue_fire = mem_req && mem_ready;
   assign write_data = mem_rdata;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (miss_detected) state_next = FILL;
         FILL:    if (ret_fire && (returned == LAST_CNT)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A return in the same cycle frees a slot, so a request may go out alongside it.
   always_comb begin
      mem_req          = 1'b0;
      mem_addr         = '0;
      fsm_busy         = (state != IDLE);
      write_data_array = 1'b0;
      data_word_idx    = '0;
      req_data_valid   = 1'b0;
      write_tag_array  = (state == DONE);
      if (state == FILL) begin
         mem_req          = (issued < BLOCK_CNT) && ((outstanding < MAX_CNT) || ret_fire);
         mem_addr         = fill_addr + (ADDR_W'(req_idx) << BYTE_W);
         write_data_array = ret_fire;
         data_word_idx    = ret_idx;
         req_data_valid   = ret_fire && (ret_idx == crit);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_addr   <= '0;
         crit        <= '0;
         issued      <= '0;
         returned    <= '0;
         outstanding <= '0;
         req_data    <= '0;
      end else begin
         if ((state == IDLE) && miss_detected) begin
            fill_addr   <= miss_address & ~OFF_MASK;
            crit        <= miss_address[OFF_W-1:BYTE_W];
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
         end else if (state == FILL) begin
            if (issue_fire) issued   <= issued + 1'b1;
            if (ret_fire)   returned <= returned + 1'b1;
            if (issue_fire && !ret_fire)      outstanding <= outstanding + 1'b1;
            else if (!issue_fire && ret_fire) outstanding <= outstanding - 1'b1;
         end
         if (ret_fire && (ret_idx == crit)) req_data <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: three instances (sequential, critical-word-first,
// two-deep outstanding) share one in-order memory model; one fills at a time.
module tb_cache_fill_ctrl;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [NI-1:0] miss;
   logic [AW-1:0] miss_address;
   logic          mem_ready, mem_rvalid, model_rv, stray_rv;
   logic [DW-1:0] mem_rdata;

   logic          mem_req_v [NI];
   logic [AW-1:0] mem_addr_v[NI];
   logic          busy_v    [NI];
   logic          wr_v      [NI];
   logic [2:0]    idx_v     [NI];
   logic [DW-1:0] wdata_v   [NI];
   logic          tag_v     [NI];
   logic [AW-1:0] fill_v    [NI];
   logic [DW-1:0] rd_v      [NI];
   logic          rdv_v     [NI];

   assign mem_rvalid = model_rv | stray_rv;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      cache_fill_ctrl #(
         .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(8),
         .MAX_OUTSTANDING((g == 2) ? 2 : 4), .CWF((g == 1) ? 1 : 0)
      ) dut (
         .clk(clk), .rst(rst),
         .miss_detected(miss[g]), .miss_address(miss_address),
         .mem_req(mem_req_v[g]), .mem_ready(mem_ready), .mem_addr(mem_addr_v[g]),
         .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
         .fsm_busy(busy_v[g]), .write_data_array(wr_v[g]), .data_word_idx(idx_v[g]),
         .write_data(wdata_v[g]), .write_tag_array(tag_v[g]), .fill_addr(fill_v[g]),
         .req_data(rd_v[g]), .req_data_valid(rdv_v[g])
      );
   end

   int sel;
   logic          s_req, s_busy, s_wr, s_tag, s_rdv;
   logic [AW-1:0] s_addr, s_fill;
   logic [2:0]    s_idx;
   logic [DW-1:0] s_wdata, s_req_data;
   assign s_req      = mem_req_v[sel];
   assign s_addr     = mem_addr_v[sel];
   assign s_busy     = busy_v[sel];
   assign s_wr       = wr_v[sel];
   assign s_idx      = idx_v[sel];
   assign s_wdata    = wdata_v[sel];
   assign s_tag      = tag_v[sel];
   assign s_fill     = fill_v[sel];
   assign s_req_data = rd_v[sel];
   assign s_rdv      = rdv_v[sel];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // In-order memory: a request accepted at edge k returns data sampled at edge k+lat.
   typedef struct packed {int due; logic [AW-1:0] addr;} pend_t;
   pend_t pend[$];
   int    cyc = 0;
   int    lat = 3;

   initial begin
      logic          fire;
      logic [AW-1:0] a;
      model_rv  = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         fire = s_req && mem_ready;
         a    = s_addr;
         cyc++;
         if (model_rv) void'(pend.pop_front());
         if (fire) pend.push_back('{due: cyc + lat, addr: a});
         #1;
         if (pend.size() > 0 && pend[0].due == cyc + 1) begin
            model_rv  = 1'b1;
            mem_rdata = mem_fn(pend[0].addr);
         end else begin
            model_rv  = 1'b0;
            mem_rdata = '0;
         end
      end
   end

   // Scoreboard: expectations are queued when a miss is driven, consumed as the DUT acts.
   logic [AW-1:0] exp_addr_q[$];
   logic [2:0]    exp_idx_q[$];
   logic [DW-1:0] exp_dat_q[$];
   logic [2:0]    exp_crit;
   int  max_sel = 4;
   int  peak = 0;
   int  wr_cnt = 0;
   int  tag_cnt = 0;
   int  last_wr_cyc = 0;
   bit  chk_req = 1'b0;

   initial forever begin
      @(negedge clk);
      if (pend.size() > peak) peak = pend.size();
      if (chk_req && exp_addr_q.size() > 0)
         check("req_rule", s_req, ((pend.size() < max_sel) || mem_rvalid) ? 1 : 0);
      if (s_req) begin
         if (exp_addr_q.size() == 0) check("req_unexpected", s_req, 0);
         else begin
            check("mem_addr", s_addr, exp_addr_q[0]);
            if (mem_ready) void'(exp_addr_q.pop_front());
         end
      end
      if (s_wr) begin
         wr_cnt++;
         last_wr_cyc = cyc;
         if (exp_idx_q.size() == 0) check("wr_unexpected", s_wr, 0);
         else begin
            check("word_idx", s_idx, exp_idx_q[0]);
            check("write_data", s_wdata, exp_dat_q[0]);
            check("req_data_valid", s_rdv, (exp_idx_q[0] == exp_crit) ? 1 : 0);
            void'(exp_idx_q.pop_front());
            void'(exp_dat_q.pop_front());
         end
      end else if (s_rdv) check("rdv_stray", s_rdv, 0);
      if (s_tag) begin
         tag_cnt++;
         check("tag_timing", cyc - last_wr_cyc, 1);
      end
   end

   task automatic start_fill(input int inst, input logic [AW-1:0] addr);
      logic [AW-1:0] b, wa;
      logic [2:0]    c, ix;
      b = addr & 16'hFFF0;
      c = addr[3:1];
      sel      = inst;
      exp_crit = c;
      max_sel  = (inst == 2) ? 2 : 4;
      peak     = 0;
      for (int i = 0; i < 8; i++) begin
         ix = (inst == 1) ? c + 3'(i) : 3'(i);
         wa = b + {12'd0, ix, 1'b0};
         exp_addr_q.push_back(wa);
         exp_idx_q.push_back(ix);
         exp_dat_q.push_back(mem_fn(wa));
      end
      miss_address = addr;
      miss[inst]   = 1'b1;
      @(posedge clk);
      #1;
      miss = '0;
      check("busy_after_miss", s_busy, 1);
      check("fill_addr", s_fill, b);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300 && s_busy; i++) @(negedge clk);
      check("busy_drop", s_busy, 0);
      check("queues_drained", exp_addr_q.size() + exp_idx_q.size(), 0);
   endtask

   initial begin
      int t0, w0;
      rst = 1'b1; miss = '0; miss_address = '0; mem_ready = 1'b1;
      stray_rv = 1'b0; sel = 0;
      #3;
      check("rst_mem_req", s_req, 0);
      check("rst_busy", s_busy, 0);
      check("rst_wr", s_wr, 0);
      check("rst_tag", s_tag, 0);
      check("rst_rdv", s_rdv, 0);
      check("rst_req_data", s_req_data, 0);
      check("rst_fill_addr", s_fill, 0);
      check("rst_mem_addr", s_addr, 0);
      check("rst_idx", s_idx, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Sequential order, latency 3
      lat = 3; t0 = tag_cnt;
      start_fill(0, 16'h1236);
      chk_req = 1'b1;
      wait_done();
      check("t1_tag_once", tag_cnt - t0, 1);
      check("t1_req_data", s_req_data, mem_fn(16'h1236));

      // Critical word first
      t0 = tag_cnt;
      start_fill(1, 16'h1236);
      wait_done();
      check("t2_tag_once", tag_cnt - t0, 1);
      check("t2_req_data", s_req_data, mem_fn(16'h1236));

      // Two outstanding, latency 5
      lat = 5; t0 = tag_cnt;
      start_fill(2, 16'h1236);
      wait_done();
      check("t3_peak_outstanding", peak, 2);
      check("t3_tag_once", tag_cnt - t0, 1);

      // Memory stalls the second request for three cycles
      lat = 3; t0 = tag_cnt; w0 = wr_cnt;
      start_fill(0, 16'h1236);
      @(posedge clk);
      #1 mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 mem_ready = 1'b1;
      wait_done();
      check("t4_writes", wr_cnt - w0, 8);
      check("t4_tag_once", tag_cnt - t0, 1);

      // Reset in the middle of a fill
      chk_req = 1'b0; t0 = tag_cnt; w0 = wr_cnt;
      start_fill(0, 16'h1236);
      for (int i = 0; i < 100 && (wr_cnt - w0) < 4; i++) begin
         @(negedge clk);
         #1;
      end
      check("t5_four_returns", wr_cnt - w0, 4);
      #2 rst = 1'b1;
      #1;
      check("t5_mem_req", s_req, 0);
      check("t5_busy", s_busy, 0);
      check("t5_wr", s_wr, 0);
      check("t5_tag", s_tag, 0);
      check("t5_rdv", s_rdv, 0);
      check("t5_req_data", s_req_data, 0);
      check("t5_fill_addr", s_fill, 0);
      check("t5_mem_addr", s_addr, 0);
      check("t5_idx", s_idx, 0);
      exp_addr_q.delete(); exp_idx_q.delete(); exp_dat_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (12) @(posedge clk);
      check("t5_no_late_writes", wr_cnt - w0, 4);
      check("t5_no_tag", tag_cnt - t0, 0);
      chk_req = 1'b1; t0 = tag_cnt;
      start_fill(0, 16'h0040);
      wait_done();
      check("t5_refill_tag", tag_cnt - t0, 1);
      check("t5_refill_req_data", s_req_data, mem_fn(16'h0040));

      // Miss while busy and stray rvalid while idle
      t0 = tag_cnt; w0 = wr_cnt;
      start_fill(0, 16'h1236);
      repeat (2) @(posedge clk);
      #1;
      miss_address = 16'h5550;
      miss[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1 miss = '0;
      check("t6_fill_addr_kept", s_fill, 16'h1230);
      wait_done();
      check("t6_writes", wr_cnt - w0, 8);
      check("t6_tag_once", tag_cnt - t0, 1);
      @(posedge clk);
      #1 stray_rv = 1'b1;
      @(negedge clk);
      check("t6_stray_write", s_wr, 0);
      @(posedge clk);
      #1 stray_rv = 1'b0;
      check("t6_idle_busy", s_busy, 0);
      check("t6_req_data_held", s_req_data, mem_fn(16'h1236));
      check("t6_fill_addr_idle", s_fill, 16'h1230);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1);
   end

endmodule
